// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main controller:
//   - controller state enumeration
//   - opcode and R-type funct field values
//   - ALU control codes and the internal ALU-operation selector
//   - alusrcb and pcsrc mux encodings
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type funct (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU control codes
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Selector from the FSM to the ALU decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // alusrcb mux
  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // pcsrc mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_multicycle_ctrl_aludec.sv
// aludec
// Combinational ALU decoder.
//   funct_i        R-type funct field
//   aluop_i        operation selector from the FSM (add / sub / use funct)
//   alucontrol_o   ALU control code
//   funct_valid_o  funct is one of the supported R-type functions; this is
//                  independent of aluop_i so DECODE can screen R-types early
module aludec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [1:0] aluop_i,
  output logic [2:0] alucontrol_o,
  output logic       funct_valid_o
);

  logic [2:0] funct_code;

  always_comb begin
    funct_code    = ALU_ADD;
    funct_valid_o = 1'b1;
    case (funct_i)
      FN_ADD:  funct_code = ALU_ADD;
      FN_SUB:  funct_code = ALU_SUB;
      FN_AND:  funct_code = ALU_AND;
      FN_OR:   funct_code = ALU_OR;
      FN_SLT:  funct_code = ALU_SLT;
      default: funct_valid_o = 1'b0;
    endcase
  end

  always_comb begin
    case (aluop_i)
      ALUOP_SUB:   alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: alucontrol_o = funct_code;
      default:     alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Main control FSM for a multicycle MIPS datapath with one unified memory.
// Sequences lw, sw, R-type, beq, addi and j one state per clock, stalling in
// FETCH / MEMRD / MEMWR until memready_i. Also counts retired instructions
// and pulses illegal_o for undecodable instructions.
// Ports:
//   clk_i, rst_i          clock (rising edge), asynchronous active-high reset
//   opcode_i, funct_i     IR[31:26], IR[5:0]
//   zero_i                ALU zero flag (only used in BRANCH)
//   memready_i            memory finishes the current access this cycle
//   pcen_o .. alucontrol_o datapath controls
//   illegal_o             one-cycle pulse in DECODE for an unknown instruction
//   retired_o             retired-instruction count, wraps mod 2^CNT_W
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             memready_i,
  output logic             pcen_o,
  output logic             iord_o,
  output logic             memread_o,
  output logic             memwrite_o,
  output logic             irwrite_o,
  output logic             regdst_o,
  output logic             memtoreg_o,
  output logic             regwrite_o,
  output logic             alusrca_o,
  output logic [1:0]       alusrcb_o,
  output logic [1:0]       pcsrc_o,
  output logic [2:0]       alucontrol_o,
  output logic             illegal_o,
  output logic [CNT_W-1:0] retired_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] retired_q;

  logic       pcwrite, branch, retire;
  logic       irwrite_raw, memwrite_raw, regwrite_raw, illegal_raw;
  logic [1:0] aluop;
  logic       funct_valid;

  aludec u_aludec (
    .funct_i       (funct_i),
    .aluop_i       (aluop),
    .alucontrol_o  (alucontrol_o),
    .funct_valid_o (funct_valid)
  );

  always_comb begin
    state_d      = state_q;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    retire       = 1'b0;
    irwrite_raw  = 1'b0;
    memwrite_raw = 1'b0;
    regwrite_raw = 1'b0;
    illegal_raw  = 1'b0;
    iord_o       = 1'b0;
    memread_o    = 1'b0;
    regdst_o     = 1'b0;
    memtoreg_o   = 1'b0;
    alusrca_o    = 1'b0;
    alusrcb_o    = SRCB_B;
    pcsrc_o      = PCSRC_ALU;
    aluop        = ALUOP_ADD;

    case (state_q)
      S_FETCH: begin
        memread_o = 1'b1;
        alusrcb_o = SRCB_FOUR;
        // IR load and PC+4 only happen in the cycle the memory delivers.
        if (memready_i) begin
          irwrite_raw = 1'b1;
          pcwrite     = 1'b1;
          state_d     = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrcb_o = SRCB_IMMSH;  // precompute branch target into ALUOut
        case (opcode_i)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_valid) begin
              state_d = S_EXEC;
            end else begin
              illegal_raw = 1'b1;
              state_d     = S_FETCH;
            end
          end
          default: begin
            illegal_raw = 1'b1;
            state_d     = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        state_d   = (opcode_i == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord_o    = 1'b1;
        memread_o = 1'b1;
        if (memready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg_o   = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_MEMWR: begin
        iord_o       = 1'b1;
        memwrite_raw = 1'b1;
        if (memready_i) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        regdst_o     = 1'b1;
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_BRANCH: begin
        alusrca_o = 1'b1;
        aluop     = ALUOP_SUB;
        pcsrc_o   = PCSRC_ALUOUT;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alusrca_o = 1'b1;
        alusrcb_o = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        regwrite_raw = 1'b1;
        retire       = 1'b1;
        state_d      = S_FETCH;
      end
      S_JUMP: begin
        pcsrc_o = PCSRC_JUMP;
        pcwrite = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Write-type strobes are masked by reset so an in-flight store is aborted
  // in the same cycle reset rises, not at the next edge.
  assign pcen_o     = ~rst_i & (pcwrite | (branch & zero_i));
  assign irwrite_o  = ~rst_i & irwrite_raw;
  assign memwrite_o = ~rst_i & memwrite_raw;
  assign regwrite_o = ~rst_i & regwrite_raw;
  assign illegal_o  = ~rst_i & illegal_raw;
  assign retired_o  = retired_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_q + {{(CNT_W-1){1'b0}}, retire};
    end
  end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl
// Directed plus randomized instruction streams. For every instruction the
// reference model expands the instruction class into its expected per-cycle
// output vectors (fetch with waits, decode, then class-specific phases) and
// the memready/zero values to drive; outputs and the retired count are
// compared every cycle. A narrow counter is used so wrap-around is exercised.
module tb_mips_multicycle_ctrl;

  localparam int CNT_W = 4;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, J = 6'b000010;

  logic clk = 1'b0;
  logic rst, zero, memready;
  logic [5:0] opcode, funct;
  logic pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [CNT_W-1:0] retired;

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct),
    .zero_i(zero), .memready_i(memready),
    .pcen_o(pcen), .iord_o(iord), .memread_o(memread), .memwrite_o(memwrite),
    .irwrite_o(irwrite), .regdst_o(regdst), .memtoreg_o(memtoreg),
    .regwrite_o(regwrite), .alusrca_o(alusrca), .alusrcb_o(alusrcb),
    .pcsrc_o(pcsrc), .alucontrol_o(alucontrol), .illegal_o(illegal),
    .retired_o(retired)
  );

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluc;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t o;
    logic  mr;
    logic  z;
    logic  ret;
  } step_t;

  step_t q[$];
  int checks = 0;
  int errors = 0;
  logic [CNT_W-1:0] exp_ret;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic outs_t base();
    outs_t r;
    r = '0;
    r.aluc = 3'b010;
    return r;
  endfunction

  function automatic outs_t observe();
    outs_t r;
    r.pcen = pcen; r.iord = iord; r.memread = memread; r.memwrite = memwrite;
    r.irwrite = irwrite; r.regdst = regdst; r.memtoreg = memtoreg;
    r.regwrite = regwrite; r.alusrca = alusrca; r.alusrcb = alusrcb;
    r.pcsrc = pcsrc; r.aluc = alucontrol; r.illegal = illegal;
    return r;
  endfunction

  function automatic logic legal_op(logic [5:0] op);
    return op == LW || op == SW || op == RT || op == BEQ || op == ADDI || op == J;
  endfunction

  // {valid, alucontrol} for an R-type funct, from the instruction table.
  function automatic logic [3:0] r_info(logic [5:0] fn);
    case (fn)
      6'b100000: return 4'b1_010;
      6'b100010: return 4'b1_110;
      6'b100100: return 4'b1_000;
      6'b100101: return 4'b1_001;
      6'b101010: return 4'b1_111;
      default:   return 4'b0_010;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(outs_t o, logic mr, logic z, logic ret);
    step_t s;
    s.o = o; s.mr = mr; s.z = z; s.ret = ret;
    q.push_back(s);
  endtask

  // Expected cycle sequence for one instruction.
  task automatic build(logic [5:0] op, logic [5:0] fn, logic z, int fwait, int mwait);
    outs_t o;
    logic [3:0] ri;
    q.delete();
    opcode = op;
    funct  = fn;
    o = base(); o.memread = 1'b1; o.alusrcb = 2'b01;
    for (int i = 0; i < fwait; i++) push(o, 1'b0, rb(), 1'b0);
    o.irwrite = 1'b1; o.pcen = 1'b1;
    push(o, 1'b1, rb(), 1'b0);
    o = base(); o.alusrcb = 2'b11;
    ri = r_info(fn);
    if (!legal_op(op) || (op == RT && !ri[3])) begin
      o.illegal = 1'b1;
      push(o, rb(), rb(), 1'b0);
      return;
    end
    push(o, rb(), rb(), 1'b0);
    case (op)
      LW, SW: begin
        o = base(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
        push(o, rb(), rb(), 1'b0);
        o = base(); o.iord = 1'b1;
        if (op == LW) o.memread = 1'b1; else o.memwrite = 1'b1;
        for (int i = 0; i < mwait; i++) push(o, 1'b0, rb(), 1'b0);
        push(o, 1'b1, rb(), op == SW);
        if (op == LW) begin
          o = base(); o.memtoreg = 1'b1; o.regwrite = 1'b1;
          push(o, rb(), rb(), 1'b1);
        end
      end
      RT: begin
        o = base(); o.alusrca = 1'b1; o.aluc = ri[2:0];
        push(o, rb(), rb(), 1'b0);
        o = base(); o.regdst = 1'b1; o.regwrite = 1'b1;
        push(o, rb(), rb(), 1'b1);
      end
      BEQ: begin
        o = base(); o.alusrca = 1'b1; o.aluc = 3'b110; o.pcsrc = 2'b01; o.pcen = z;
        push(o, rb(), z, 1'b1);
      end
      ADDI: begin
        o = base(); o.alusrca = 1'b1; o.alusrcb = 2'b10;
        push(o, rb(), rb(), 1'b0);
        o = base(); o.regwrite = 1'b1;
        push(o, rb(), rb(), 1'b1);
      end
      default: begin
        o = base(); o.pcsrc = 2'b10; o.pcen = 1'b1;
        push(o, rb(), rb(), 1'b1);
      end
    endcase
  endtask

  // Executes the first n queued cycles. Called just after a falling edge.
  task automatic run(string tag, int n);
    for (int i = 0; i < n; i++) begin
      memready = q[i].mr;
      zero     = q[i].z;
      #1;
      check($sformatf("%s[%0d].outs", tag, i), 32'(observe()), 32'(q[i].o));
      check($sformatf("%s[%0d].retired", tag, i), 32'(retired), 32'(exp_ret));
      @(posedge clk);
      if (q[i].ret) exp_ret = exp_ret + 1'b1;
      @(negedge clk);
    end
    $display("txn %-10s op=%b fn=%b cycles=%0d retired_exp=%0d checks=%0d errors=%0d",
             tag, opcode, funct, n, exp_ret, checks, errors);
  endtask

  task automatic do_instr(string tag, logic [5:0] op, logic [5:0] fn, logic z, int fw, int mw);
    build(op, fn, z, fw, mw);
    run(tag, q.size());
  endtask

  task automatic check_reset_outs(string tag);
    check({tag, ".pcen"},     32'(pcen),     32'd0);
    check({tag, ".irwrite"},  32'(irwrite),  32'd0);
    check({tag, ".memwrite"}, 32'(memwrite), 32'd0);
    check({tag, ".regwrite"}, 32'(regwrite), 32'd0);
    check({tag, ".illegal"},  32'(illegal),  32'd0);
    check({tag, ".retired"},  32'(retired),  32'd0);
  endtask

  initial begin
    logic [5:0] op, fn;
    rst = 1'b1; zero = 1'b0; memready = 1'b1; opcode = 6'b0; funct = 6'b0;
    exp_ret = '0;

    // Reset state, with memready high so FETCH gating must hold.
    #1;
    check_reset_outs("reset0");
    @(posedge clk); @(negedge clk);
    #1;
    check_reset_outs("reset1");
    rst = 1'b0;

    // Directed scenarios
    do_instr("lw",      LW,   6'b010101, 1'b0, 0, 0);
    do_instr("sw_wait", SW,   6'b000000, 1'b0, 0, 3);
    do_instr("beq_z1",  BEQ,  6'b000000, 1'b1, 0, 0);
    do_instr("beq_z0",  BEQ,  6'b000000, 1'b0, 0, 0);
    do_instr("r_slt",   RT,   6'b101010, 1'b0, 0, 0);
    do_instr("r_bad",   RT,   6'b000000, 1'b0, 0, 0);
    do_instr("op_3f",   6'b111111, 6'b100000, 1'b0, 0, 0);
    do_instr("addi",    ADDI, 6'b000000, 1'b0, 1, 0);
    do_instr("j",       J,    6'b000000, 1'b0, 2, 0);

    // Randomized instruction stream
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0: op = LW;   1: op = SW;  2: op = RT;  3: op = BEQ;
        4: op = ADDI; 5: op = J;
        default: begin
          op = 6'($urandom);
          while (legal_op(op)) op = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        0: fn = 6'b100000; 1: fn = 6'b100010; 2: fn = 6'b100100;
        3: fn = 6'b100101; 4: fn = 6'b101010;
        default: fn = 6'($urandom);
      endcase
      do_instr($sformatf("rand%0d", n), op, fn, rb(),
               int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // Reset while a store is waiting on memory.
    build(SW, 6'b000000, 1'b0, 1, 5);
    run("sw_abort", 6);
    memready = 1'b0;
    #1;
    check("sw_abort.pre_memwrite", 32'(memwrite), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_outs("sw_abort.rst");
    memready = 1'b1;
    #1;
    check_reset_outs("sw_abort.rst_mr");
    exp_ret = '0;
    @(negedge clk);
    rst = 1'b0;
    do_instr("post_rst", ADDI, 6'b000000, 1'b0, 0, 0);
    do_instr("post_lw",  LW,   6'b000000, 1'b0, 1, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
